// File: rtl/gf_pkg.sv
// Shared types and constants for the GF(2^m) exponentiation controller.
package gf_pkg;

  localparam int GF_MAX_M = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQR  = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Multiplicative identity; callers take the low m bits.
  function automatic logic [GF_MAX_M-1:0] gf_one();
    return {{(GF_MAX_M-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/gf_2m_mult.sv
// Combinational GF(2^m) multiplier, polynomial basis, monic modulus x^m + p.
module gf_2m_mult #(
  parameter int m = 4
) (
  input  logic [m-1:0] a,
  input  logic [m-1:0] b,
  input  logic [m-1:0] p,
  output logic [m-1:0] y
);

  logic [m-1:0] acc;
  logic [m-1:0] bb;
  logic         msb;

  // Shift-and-add: bb walks through b*x^i mod (x^m + p).
  always_comb begin
    acc = '0;
    bb  = b;
    msb = 1'b0;
    for (int i = 0; i < m; i++) begin
      if (a[i]) acc = acc ^ bb;
      msb = bb[m-1];
      bb  = bb << 1;
      if (msb) bb = bb ^ p;
    end
  end

  assign y = acc;

endmodule

// File: rtl/gf_2m_exp_ctrl.sv
// Left-to-right square-and-multiply exponentiation / inversion in GF(2^m),
// one shared multiplier, one multiplication per cycle.
module gf_2m_exp_ctrl
  import gf_pkg::*;
#(
  parameter int m = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [m-1:0] a,
  input  logic [m-1:0] e,
  input  logic         inv,
  input  logic [m-1:0] p,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [m-1:0] y
);

  localparam int                    KW    = (m > 1) ? $clog2(m) : 1;
  localparam logic [GF_MAX_M-1:0]   ONE_W = gf_one();
  localparam logic [m-1:0]          ONE   = ONE_W[m-1:0];
  localparam logic [KW-1:0]         K_TOP = KW'(m - 1);
  // a^(2^m - 2) is the inverse for a != 0 and maps 0 to 0.
  localparam logic [m-1:0]          E_INV = {{(m-1){1'b1}}, 1'b0};

  state_t        state;
  state_t        state_nxt;
  logic [KW-1:0] k;
  logic [KW-1:0] k_nxt;
  logic [m-1:0]  a_reg;
  logic [m-1:0]  p_reg;
  logic [m-1:0]  e_reg;
  logic [m-1:0]  r;
  logic [m-1:0]  op_b;
  logic [m-1:0]  prod;

  assign op_b = (state == MUL) ? a_reg : r;

  gf_2m_mult #(.m(m)) u_mult (
    .a (r),
    .b (op_b),
    .p (p_reg),
    .y (prod)
  );

  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_nxt = SQR;
          k_nxt     = K_TOP;
        end
      end
      SQR: begin
        if (e_reg[k])       state_nxt = MUL;
        else if (k != '0)   k_nxt     = k - 1'b1;
        else                state_nxt = DONE;
      end
      MUL: begin
        if (k != '0) begin
          state_nxt = SQR;
          k_nxt     = k - 1'b1;
        end else begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      k         <= K_TOP;
      a_reg     <= '0;
      p_reg     <= '0;
      e_reg     <= '0;
      r         <= '0;
      y         <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state     <= state_nxt;
      k         <= k_nxt;
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            p_reg <= p;
            e_reg <= inv ? E_INV : e;
            r     <= ONE;
          end
        end
        SQR, MUL: begin
          r <= prod;
          if (state_nxt == DONE) y <= prod;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gf_2m_exp_ctrl.sv
// Scoreboard bench for gf_2m_exp_ctrl over GF(16), modulus x^4 + x + 1.
module tb_gf_2m_exp_ctrl;

  localparam int          M = 4;
  localparam logic [3:0]  P = 4'b0011;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] e;
  logic       inv;
  logic [3:0] p;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] y;

  typedef struct {
    logic [3:0] y;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  gf_2m_exp_ctrl #(.m(M)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .e         (e),
    .inv       (inv),
    .p         (p),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
  );

  always #5 clk = ~clk;

  // Schoolbook carry-less product then long-division reduction.
  function automatic logic [3:0] ref_mul(input logic [3:0] x, input logic [3:0] z);
    logic [7:0] w;
    logic [7:0] poly;
    w    = 8'h00;
    poly = {3'b000, 1'b1, P};
    for (int i = 0; i < 4; i++)
      if (z[i]) w = w ^ (8'(x) << i);
    for (int i = 7; i >= 4; i--)
      if (w[i]) w = w ^ (poly << (i - 4));
    return w[3:0];
  endfunction

  // Repeated multiplication, independent of the DUT's bit-scan order.
  function automatic logic [3:0] ref_pow(input logic [3:0] x, input logic [3:0] ex);
    logic [3:0] acc;
    acc = 4'd1;
    for (int i = 0; i < int'(ex); i++) acc = ref_mul(acc, x);
    return acc;
  endfunction

  task automatic issue(input logic [3:0] ai, input logic [3:0] ei, input logic ii,
                       input logic [3:0] ey, input int el);
    int n;
    exp_t x;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 50) begin
      bad++;
      $display("FAIL issue_ready: in_ready=%0b required=1", in_ready);
    end
    a = ai; e = ei; inv = ii; in_valid = 1'b1;
    x.y = ey; x.lat = el;
    sb.push_back(x);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 4'($urandom_range(0, 15));
    e = 4'($urandom_range(0, 15));
    inv = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_result(output logic [3:0] yo, output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 64);
    yo = y;
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = 4'd0; e = 4'd0; inv = 1'b0; p = P;
    repeat (2) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b1; a = 4'd2; e = 4'd3;
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    total += 3;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got=%0b want=1", in_ready); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got=%0b want=0", out_valid); end
    if (y !== 4'd0) begin bad++; $display("FAIL reset_y: got=%0d want=0", y); end
    @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_req_dropped: in_ready=%0b want=1", in_ready); end
  endtask

  task automatic test_directed();
    logic [3:0] tv_a  [5] = '{4'd2, 4'd2, 4'd0, 4'd3, 4'd0};
    logic [3:0] tv_e  [5] = '{4'd3, 4'd5, 4'd7, 4'd15, 4'd0};
    logic       tv_i  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [3:0] tv_y  [5] = '{4'd8, 4'd9, 4'd0, 4'd1, 4'd1};
    int         tv_l  [5] = '{6, 7, 7, 8, 4};
    logic [3:0] yo;
    int lat;
    exp_t x;
    for (int i = 0; i < 5; i++) begin
      issue(tv_a[i], tv_e[i], tv_i[i], tv_y[i], tv_l[i]);
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL dir_busy_%0d: in_ready=%0b want=0", i, in_ready); end
      wait_result(yo, lat);
      if (sb.size() > 0) begin
        x = sb.pop_front();
        total += 2;
        if (yo !== x.y) begin bad++; $display("FAIL dir_y_%0d: got=%0d want=%0d", i, yo, x.y); end
        if (lat != x.lat) begin bad++; $display("FAIL dir_lat_%0d: got=%0d want=%0d", i, lat, x.lat); end
      end
      release_result();
      total += 2;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL dir_idle_%0d: in_ready=%0b want=1", i, in_ready); end
      if (out_valid !== 1'b0) begin bad++; $display("FAIL dir_ov_drop_%0d: out_valid=%0b want=0", i, out_valid); end
    end
  endtask

  task automatic test_hold();
    logic [3:0] yo;
    int lat;
    exp_t x;
    @(negedge clk);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b0;
    total += 2;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL idle_oready_ov: got=%0b want=0", out_valid); end
    if (in_ready !== 1'b1) begin bad++; $display("FAIL idle_oready_ir: got=%0b want=1", in_ready); end
    issue(4'd2, 4'd3, 1'b0, 4'd8, 6);
    wait_result(yo, lat);
    if (sb.size() > 0) begin
      x = sb.pop_front();
      total += 2;
      if (yo !== x.y) begin bad++; $display("FAIL hold_y: got=%0d want=%0d", yo, x.y); end
      if (lat != x.lat) begin bad++; $display("FAIL hold_lat: got=%0d want=%0d", lat, x.lat); end
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 4'd3; e = 4'd1;
      @(posedge clk);
      #1;
      total += 3;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL hold_ov_%0d: got=%0b want=1", c, out_valid); end
      if (y !== 4'd8) begin bad++; $display("FAIL hold_y_%0d: got=%0d want=8", c, y); end
      if (in_ready !== 1'b0) begin bad++; $display("FAIL hold_ir_%0d: got=%0b want=0", c, in_ready); end
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    total += 3;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL hold_rel_ir: got=%0b want=1", in_ready); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL hold_rel_ov: got=%0b want=0", out_valid); end
    if (y !== 4'd8) begin bad++; $display("FAIL hold_rel_y_kept: got=%0d want=8", y); end
    @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL hold_no_queue: in_ready=%0b want=1", in_ready); end
  endtask

  task automatic test_reset_midflight();
    logic [3:0] yo;
    int lat;
    int seen;
    exp_t x;
    issue(4'd2, 4'd3, 1'b0, 4'd8, 6);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    if (sb.size() > 0) void'(sb.pop_back());
    total += 3;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_ir: got=%0b want=1", in_ready); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_ov: got=%0b want=0", out_valid); end
    if (y !== 4'd0) begin bad++; $display("FAIL mid_rst_y: got=%0d want=0", y); end
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0 || y !== 4'd0) seen++;
    end
    total++;
    if (seen != 0) begin bad++; $display("FAIL mid_discarded: leak_cycles=%0d want=0", seen); end
    issue(4'd2, 4'd3, 1'b0, 4'd8, 6);
    wait_result(yo, lat);
    if (sb.size() > 0) begin
      x = sb.pop_front();
      total += 2;
      if (yo !== x.y) begin bad++; $display("FAIL mid_after_y: got=%0d want=%0d", yo, x.y); end
      if (lat != x.lat) begin bad++; $display("FAIL mid_after_lat: got=%0d want=%0d", lat, x.lat); end
    end
    release_result();
  endtask

  task automatic test_random();
    logic [3:0] ra, re, ee, yo;
    logic       ri;
    int lat;
    exp_t x;
    for (int n = 0; n < 1000; n++) begin
      ra = 4'($urandom_range(0, 15));
      re = 4'($urandom_range(0, 15));
      ri = ($urandom_range(0, 3) == 0);
      ee = ri ? 4'b1110 : re;
      issue(ra, re, ri, ref_pow(ra, ee), M + $countones(ee));
      wait_result(yo, lat);
      if (sb.size() > 0) begin
        x = sb.pop_front();
        total += 2;
        if (yo !== x.y) begin
          bad++;
          $display("FAIL rand_y: a=%0d e=%0d inv=%0b got=%0d want=%0d", ra, re, ri, yo, x.y);
        end
        if (lat != x.lat) begin
          bad++;
          $display("FAIL rand_lat: a=%0d e=%0d inv=%0b got=%0d want=%0d", ra, re, ri, lat, x.lat);
        end
      end
      release_result();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_reset_midflight();
    test_random();
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL sb_leftover: size=%0d want=0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
